mem_stage_dcache: RTL and testbench
===================================

# mem_stage_dcache

Data-memory stage of the 16-bit pipeline. It sits between the EX/MEM pipeline register and the MEM/WB pipeline register. It serves loads from a direct-mapped, one-word-per-line cache and writes stores through to a backing memory using a req/ack handshake. Its `hit` output is the MEM/WB load enable and the upstream stall release, so the pipeline advances only when the stage's result is valid.

## Interface
Parameters:
- `INDEX_BITS`, default 3: cache has 2^INDEX_BITS lines. Tag is `addr[15:INDEX_BITS]`. Addresses are word addresses.

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- `clk` in 1: sole clock. All state updates on posedge. MEM/WB samples `hit`/`readData` on negedge.
- `rst_n` in 1: asynchronous active-low reset.
- `memRead` in 1: load request from EX/MEM.
- `memWrite` in 1: store request from EX/MEM.
- `addr` in 16: word address (ALU result).
- `writeData` in 16: store data.
- `readData` out 16: load result to MEM/WB.
- `hit` out 1: stage result valid. Stage is not stalled.
- `memReq` out 1: backing-memory request. Registered.
- `memWe` out 1: backing-memory write enable. Registered, qualifies `memReq`.
- `memAddr` out 16: backing-memory address. Registered.
- `memWdata` out 16: backing-memory write data. Registered.
- `memAck` in 1: backing memory done. For reads, `memRdata` is valid in the same cycle.
- `memRdata` in 16: backing-memory read data.

## Operation
- Storage: per line, a `valid` bit, a tag of 16-INDEX_BITS bits, and 16 bits of data.
- FSM states: IDLE, RD_WAIT, WR_WAIT, DONE.
- **IDLE, no request:** `hit`=1. `readData` holds its last value.
- **IDLE, `memRead`, valid and tag match:**
  - `hit`=1 combinationally.
  - `readData` = line data combinationally.
  - State stays IDLE.
- **IDLE, `memRead`, miss:**
  - `hit`=0.
  - At the posedge, go to RD_WAIT and register `memReq`=1, `memWe`=0, `memAddr`=`addr`.
- **IDLE, `memWrite`** (write-through, no-write-allocate):
  - `hit`=0.
  - At the posedge, if valid and tag match, update the line data with `writeData`. On a miss the cache is unchanged.
  - Go to WR_WAIT and register `memReq`=1, `memWe`=1, `memAddr`, `memWdata`.
- **`memRead` and `memWrite` both high:** treated as a write.
- **RD_WAIT / WR_WAIT:**
  - `hit`=0.
  - `memReq` and its address/data stay stable until `memAck` is sampled high at a posedge.
  - On that edge, `memReq` drops to 0 and the state goes to DONE.
  - RD_WAIT only: the edge also sets the line to valid, the new tag and `memRdata`, and captures `memRdata` into the `readData` register.
- **DONE:**
  - `hit`=1.
  - `readData` = captured fill value (reads). For writes it is unchanged.
  - The next posedge unconditionally returns to IDLE. Upstream has advanced by then, so the request is not re-evaluated in DONE.
- **`memAck` while `memReq`=0:** ignored.
- **Reset** (asynchronous, any state including mid-transaction):
  - State goes to IDLE and all `valid` bits clear.
  - `memReq`=0, `memWe`=0, `memAddr`=0, `memWdata`=0, `readData`=0.
  - An outstanding backing transaction is abandoned. A later stray `memAck` is ignored.
  - After reset, `hit` follows the IDLE rules.
- Tag and data arrays need no reset. Only `valid` does.

## Timing
- Read hit: 0 added cycles. `hit` and `readData` are valid before the negedge of the request cycle.
- Read miss, with ack sampled N posedges after the request posedge (N≥1):
  - `hit` low for N+1 half-clock-aligned cycles.
  - DONE cycle = N+1 cycles after the request is first presented.
  - Total stage occupancy is N+2 cycles.
- Store: same occupancy as a read miss, whether the store hits or misses.
- `hit` depends combinationally only on the state, `memRead`, `memWrite`, `addr` and the arrays. It must settle within half a clock for the negedge capture.
- A read hit to a line in the cycle immediately after a fill or write returns the updated data.

## Test plan
- Reset, then read at `addr`=0x0012 with ack after 3 cycles and `memRdata`=0xBEEF → `memReq`/`memAddr`=0x0012 for 3 cycles, `hit`=0 for 4 cycles, then `hit`=1 with `readData`=0xBEEF. An immediate re-read of 0x0012 hits with no `memReq`.
- Write 0x1234 to a cached 0x0012 → `memReq`=1, `memWe`=1, `memWdata`=0x1234 until ack, then DONE. A following read of 0x0012 hits and returns 0x1234.
- Write to uncached 0x0044, then read 0x0044 → the write does not allocate, so the read misses and issues `memReq`.
- Conflict: fill 0x0012, then read 0x0112 (same index, different tag) → miss and refill. A re-read of 0x0012 misses again.
- Assert `rst_n`=0 during RD_WAIT → `memReq` drops immediately. After release, a pulse of `memAck` is ignored and a read of the earlier address misses.
- `memRead` and `memWrite` both asserted → the stage performs a write-through (`memWe`=1) and the cache does not fill.

Source files
------------

// File: rtl/mem_stage_dcache_if.sv
// Backing-memory bus between the data-cache stage (master) and the memory (slave).
interface mem_stage_dcache_if;
   logic        memReq;
   logic        memWe;
   logic [15:0] memAddr;
   logic [15:0] memWdata;
   logic        memAck;
   logic [15:0] memRdata;

   modport master (output memReq, memWe, memAddr, memWdata, input memAck, memRdata);
   modport slave  (input memReq, memWe, memAddr, memWdata, output memAck, memRdata);
endinterface

// File: rtl/mem_stage_dcache.sv
// MEM stage: direct-mapped one-word-per-line read cache with write-through,
// no-write-allocate stores over a req/ack backing-memory bus.
module mem_stage_dcache #(
   parameter int INDEX_BITS = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               memRead,
   input  logic               memWrite,
   input  logic [15:0]        addr,
   input  logic [15:0]        writeData,
   output logic [15:0]        readData,
   output logic               hit,
   mem_stage_dcache_if.master mem
);
   localparam int LINES = 1 << INDEX_BITS;
   localparam int TAG_W = 16 - INDEX_BITS;

   typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, DONE} state_t;

   state_t                  state, state_nxt;
   logic [LINES-1:0]        valid;
   logic [TAG_W-1:0]        tags [LINES];
   logic [15:0]             data [LINES];
   logic [15:0]             rd_q;
   logic [INDEX_BITS-1:0]   idx, fill_idx;
   logic [TAG_W-1:0]        tag, fill_tag;
   logic                    lookup, is_wr, is_rd;

   assign idx      = addr[INDEX_BITS-1:0];
   assign tag      = addr[15:INDEX_BITS];
   assign fill_idx = mem.memAddr[INDEX_BITS-1:0];
   assign fill_tag = mem.memAddr[15:INDEX_BITS];
   assign lookup   = valid[idx] && (tags[idx] == tag);
   // A simultaneous read+write request is handled as a store.
   assign is_wr    = memWrite;
   assign is_rd    = memRead && !memWrite;

   always_comb begin
      state_nxt = state;
      hit       = 1'b0;
      readData  = rd_q;
      case (state)
         IDLE: begin
            if (is_wr) begin
               state_nxt = WR_WAIT;
            end else if (is_rd) begin
               if (lookup) begin
                  hit      = 1'b1;
                  readData = data[idx];
               end else begin
                  state_nxt = RD_WAIT;
               end
            end else begin
               hit = 1'b1;
            end
         end
         RD_WAIT, WR_WAIT: begin
            if (mem.memAck) state_nxt = DONE;
         end
         DONE: begin
            hit       = 1'b1;
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid        <= '0;
         mem.memReq   <= 1'b0;
         mem.memWe    <= 1'b0;
         mem.memAddr  <= '0;
         mem.memWdata <= '0;
         rd_q         <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (is_wr) begin
                  mem.memReq   <= 1'b1;
                  mem.memWe    <= 1'b1;
                  mem.memAddr  <= addr;
                  mem.memWdata <= writeData;
               end else if (is_rd && !lookup) begin
                  mem.memReq  <= 1'b1;
                  mem.memWe   <= 1'b0;
                  mem.memAddr <= addr;
               end else if (is_rd) begin
                  // Keep the hit value so readData holds it once the request goes away.
                  rd_q <= data[idx];
               end
            end
            RD_WAIT: begin
               if (mem.memAck) begin
                  mem.memReq      <= 1'b0;
                  mem.memWe       <= 1'b0;
                  valid[fill_idx] <= 1'b1;
                  rd_q            <= mem.memRdata;
               end
            end
            WR_WAIT: begin
               if (mem.memAck) begin
                  mem.memReq <= 1'b0;
                  mem.memWe  <= 1'b0;
               end
            end
            DONE: ;
         endcase
      end
   end

   // Tag/data arrays carry no reset; the valid bits gate them.
   always_ff @(posedge clk) begin
      if (state == IDLE && is_wr && lookup) begin
         data[idx] <= writeData;
      end else if (state == RD_WAIT && mem.memAck) begin
         tags[fill_idx] <= fill_tag;
         data[fill_idx] <= mem.memRdata;
      end
   end
endmodule

// File: tb/tb_mem_stage_dcache.sv
// Directed plus randomized bench for mem_stage_dcache against a line-map reference model.
module tb_mem_stage_dcache;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        memRead, memWrite;
   logic [15:0] addr, writeData, readData;
   logic        hit;

   mem_stage_dcache_if bus ();

   mem_stage_dcache #(.INDEX_BITS(3)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .memRead   (memRead),
      .memWrite  (memWrite),
      .addr      (addr),
      .writeData (writeData),
      .readData  (readData),
      .hit       (hit),
      .mem       (bus.master)
   );

   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference: which full address each index currently holds, and its data.
   logic [15:0] cline_addr [int];
   logic [15:0] cline_data [int];
   logic [15:0] rd_model;

   task automatic check(input string tg, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tg, obs, exp);
      end
   endtask

   task automatic idle_chk();
      memRead  = 1'b0;
      memWrite = 1'b0;
      @(negedge clk);
      check("idle_hit", 16'(hit), 16'd1);
      check("idle_rdata", readData, rd_model);
      check("idle_noreq", 16'(bus.memReq), 16'd0);
      @(posedge clk); #1;
   endtask

   task automatic do_op(input bit rd, input bit wr, input logic [15:0] a,
                        input logic [15:0] wd, input int n, input logic [15:0] rdat);
      int idx;
      bit cached;
      idx    = int'(a % 16'd8);
      cached = cline_addr.exists(idx) && (cline_addr[idx] == a);
      memRead   = rd;
      memWrite  = wr;
      addr      = a;
      writeData = wd;
      @(negedge clk);
      if (rd && !wr && cached) begin
         check("rdhit_hit", 16'(hit), 16'd1);
         check("rdhit_data", readData, cline_data[idx]);
         check("rdhit_noreq", 16'(bus.memReq), 16'd0);
         rd_model = cline_data[idx];
         @(posedge clk); #1;
      end else begin
         check("req_cyc_hit", 16'(hit), 16'd0);
         check("req_cyc_noreq", 16'(bus.memReq), 16'd0);
         for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            check("wait_hit", 16'(hit), 16'd0);
            check("wait_req", 16'(bus.memReq), 16'd1);
            check("wait_we", 16'(bus.memWe), 16'(wr));
            check("wait_addr", bus.memAddr, a);
            if (wr) check("wait_wdata", bus.memWdata, wd);
            if (c == n) begin
               bus.memAck   = 1'b1;
               bus.memRdata = rdat;
            end
         end
         @(posedge clk); #1;
         bus.memAck   = 1'b0;
         bus.memRdata = 16'($urandom);
         if (wr) begin
            if (cached) cline_data[idx] = wd;
         end else begin
            cline_addr[idx] = a;
            cline_data[idx] = rdat;
            rd_model        = rdat;
         end
         @(negedge clk);
         check("done_hit", 16'(hit), 16'd1);
         check("done_noreq", 16'(bus.memReq), 16'd0);
         check("done_rdata", readData, rd_model);
         @(posedge clk); #1;
      end
      memRead  = 1'b0;
      memWrite = 1'b0;
   endtask

   initial begin
      logic [15:0] ra;
      int          op;
      rst_n        = 1'b0;
      memRead      = 1'b0;
      memWrite     = 1'b0;
      addr         = '0;
      writeData    = '0;
      bus.memAck   = 1'b0;
      bus.memRdata = '0;
      rd_model     = '0;
      #12;
      check("rst_req", 16'(bus.memReq), 16'd0);
      check("rst_we", 16'(bus.memWe), 16'd0);
      check("rst_addr", bus.memAddr, 16'd0);
      check("rst_wdata", bus.memWdata, 16'd0);
      check("rst_rdata", readData, 16'd0);
      check("rst_hit", 16'(hit), 16'd1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      idle_chk();

      // Fill, re-read, store hit, store miss (no allocate), conflict.
      do_op(1, 0, 16'h0012, 16'h0000, 3, 16'hBEEF);
      do_op(1, 0, 16'h0012, 16'h0000, 1, 16'h0000);
      do_op(0, 1, 16'h0012, 16'h1234, 2, 16'h0000);
      do_op(1, 0, 16'h0012, 16'h0000, 1, 16'h0000);
      do_op(0, 1, 16'h0044, 16'hA5A5, 1, 16'h0000);
      do_op(1, 0, 16'h0044, 16'h0000, 2, 16'h5A5A);
      do_op(1, 0, 16'h0112, 16'h0000, 1, 16'hCAFE);
      do_op(1, 0, 16'h0012, 16'h0000, 2, 16'h1234);
      idle_chk();
      // Read and write together act as a store; the line must not fill.
      do_op(1, 1, 16'h0033, 16'h7777, 2, 16'hDEAD);
      do_op(1, 0, 16'h0033, 16'h0000, 1, 16'h7777);

      // Reset in the middle of a read miss.
      memRead = 1'b1;
      addr    = 16'h0099;
      @(negedge clk);
      check("rstmid_miss", 16'(hit), 16'd0);
      @(posedge clk); #1;
      @(negedge clk);
      check("rstmid_req_before", 16'(bus.memReq), 16'd1);
      #2 rst_n = 1'b0;
      memRead = 1'b0;
      #1;
      check("rstmid_req_drop", 16'(bus.memReq), 16'd0);
      check("rstmid_addr", bus.memAddr, 16'd0);
      check("rstmid_rdata", readData, 16'd0);
      check("rstmid_hit", 16'(hit), 16'd1);
      cline_addr.delete();
      cline_data.delete();
      rd_model = '0;
      @(posedge clk); #1;
      rst_n        = 1'b1;
      bus.memAck   = 1'b1;
      bus.memRdata = 16'hFFFF;
      @(negedge clk);
      check("stray_ack_req", 16'(bus.memReq), 16'd0);
      check("stray_ack_hit", 16'(hit), 16'd1);
      @(posedge clk); #1;
      bus.memAck = 1'b0;
      idle_chk();
      do_op(1, 0, 16'h0012, 16'h0000, 1, 16'h4321);
      do_op(1, 0, 16'h0099, 16'h0000, 2, 16'h9999);

      // Randomized traffic over four tags so hits and conflicts are common.
      for (int i = 0; i < 120; i++) begin
         ra = 16'((($urandom_range(0, 3) * 16'h1234) & 16'hFFF8) | $urandom_range(0, 7));
         op = int'($urandom_range(0, 9));
         if (op <= 5)
            do_op(1, 0, ra, 16'($urandom), int'($urandom_range(1, 4)), 16'($urandom));
         else if (op <= 8)
            do_op(0, 1, ra, 16'($urandom), int'($urandom_range(1, 4)), 16'($urandom));
         else
            do_op(1, 1, ra, 16'($urandom), int'($urandom_range(1, 4)), 16'($urandom));
         if ($urandom_range(0, 4) == 0) idle_chk();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
